// File: rtl/irq_request_latch.sv
// Request latch feeding the 8-to-3 priority encoder: edge-detects req into pending bits and
// handshakes service through ack/ack_id. Define IRQ_REQ_SYNC_EN to add a 2-flop req synchronizer.
module irq_request_latch (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       ack,
    input  logic [2:0] ack_id,
    output logic [7:0] X,
    output logic       E,
    output logic       irq,
    output logic [7:0] overrun
);

    typedef enum logic [1:0] {StIdle, StAssert, StHold} state_e;

    state_e     state_q, state_d;
    logic [7:0] req_s;
    logic [7:0] req_q;
    logic [7:0] req_edge;
    logic [7:0] pend_q, pend_d;
    logic [7:0] overrun_q;
    logic [7:0] active;

`ifdef IRQ_REQ_SYNC_EN
    logic [7:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= req;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req;
`endif

    // req_q resets low so a line already high at reset release registers as an edge.
    assign req_edge = req_s & ~req_q;
    assign active   = pend_q & mask;

    always_comb begin
        pend_d = pend_q;
        if (state_q == StAssert && ack) begin
            pend_d[ack_id] = 1'b0;
        end
        pend_d = pend_d | req_edge;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q     <= 8'h00;
            pend_q    <= 8'h00;
            overrun_q <= 8'h00;
        end else begin
            req_q     <= req_s;
            pend_q    <= pend_d;
            overrun_q <= overrun_q | (req_edge & pend_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (|active) state_d = StAssert;
            end
            StAssert: begin
                if (ack) begin
                    state_d = StHold;
                end else if (active == 8'h00) begin
                    state_d = StIdle;
                end
            end
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        E   = 1'b1;
        irq = 1'b0;
        if (state_q == StAssert) begin
            E   = 1'b0;
            irq = 1'b1;
        end
    end

    assign X       = active;
    assign overrun = overrun_q;

endmodule

// File: doc/irq_request_latch.md
# irq_request_latch

- Upstream request stage for the 8-to-3 priority encoder.
- Edge-detects eight request lines and holds them as pending bits; it has no priority logic of its own.
- Drives the encoder's request vector `X[7:0]` and its active-low enable `E`.
- Retires the serviced bit through a simple `ack`/`ack_id` handshake, which the consumer of the encoder output `Y` returns.

## Interface
Parameters:
- none (width fixed at 8 to match the encoder).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  8  raw request lines; a rising edge on `req[i]` sets `pend[i]`.
- `mask`  in  8  per-line enable; 1 = line may be presented; combinational into `X`.
- `ack`  in  1  service acknowledge; sampled only in state ASSERT.
- `ack_id`  in  3  index of the line being acknowledged (normally the encoder's `Y`).
- `X`  out  8  request vector to the encoder; `pend & mask`.
- `E`  out  1  encoder enable, active-low; 0 only in state ASSERT.
- `irq`  out  1  1 only in state ASSERT.
- `overrun`  out  8  sticky per-line flag: an edge arrived while that bit was already pending.

## Operation
Edge detection:
- `req_d` holds `req` delayed by one cycle.
- `edge = req & ~req_d`.
- `req_d` resets to 0, so a line already high at reset release counts as an edge.

Pending register:
- `pend[i]` is set by `edge[i]`.
- `pend[i]` is cleared by an accepted ack with `ack_id == i`.
- Set and clear on the same bit in the same cycle: set wins and the bit stays pending.

Overrun:
- `overrun[i]` sets when `edge[i]` occurs while `pend[i]` is already 1.
- It clears only on `rst`.

FSM (3 states, registered):
- IDLE: `E` = 1, `irq` = 0.
  - Go to ASSERT when `|(pend & mask)`.
- ASSERT: `E` = 0, `irq` = 1.
  - If `ack` = 1, clear `pend[ack_id]` and go to HOLD.
  - Otherwise, if `(pend & mask)` = 0 (lines masked off), abandon and go to IDLE.
  - `ack` has priority over abandon.
- HOLD: `E` = 1, `irq` = 0, lockout for one cycle.
  - Always go to IDLE next.
  - Gives the encoder a blanked cycle while the cleared bit settles.

Other rules:
- `ack` in IDLE or HOLD is ignored.
- An `ack_id` that points at a non-pending bit clears nothing; the FSM still goes to HOLD.
- `X` is always `pend & mask`, whatever the state; the encoder forces `Y` = 0 through `E` outside ASSERT.

## Timing
Reset values:
- `pend` = 0, `req_d` = 0, `overrun` = 0, state IDLE.
- Outputs: `X` = 0, `E` = 1, `irq` = 0.
- Reset mid-operation drops every pending request immediately, including one in ASSERT.

Latency, without the synchronizer:
- `req` rises before edge *n*.
- `pend` is set at edge *n*.
- ASSERT (`irq` = 1, `E` = 0) from edge *n+1*.
- Minimum request-to-`irq` latency is 2 cycles.

Latency, with the synchronizer:
- Add 2 cycles.

Ack turnaround:
- `ack` sampled high at edge *k* in ASSERT: HOLD from *k*, IDLE from *k+1*.
- Re-ASSERT no earlier than *k+2* if further bits are pending.
- Sustained throughput is one service per 3 cycles.

Mask timing:
- Mask changes reach `X` in the same cycle (combinational).
- They affect FSM transitions at the next edge.

## Configuration
`IRQ_REQ_SYNC_EN`:
- Defined: `req` passes through a 2-flop synchronizer (reset to 0) before edge detection. Use this for asynchronous request sources. Adds 2 cycles of latency.
- Undefined: `req` must be synchronous to `clk` and feeds `req_d` and the edge logic directly.
- All other behaviour is identical in both builds.

## Test plan
1. Reset asserted with `req` = 8'hFF → `X` = 0, `E` = 1, `irq` = 0, `overrun` = 0. After release, with `req` still 8'hFF and `mask` = 8'hFF → `pend` = 8'hFF, `X` = 8'hFF, `irq` = 1 two cycles later.
2. Pulse `req[5]`, `mask` = 8'hFF → `irq` = 1 and `E` = 0 at +2 cycles. `ack` = 1 with `ack_id` = 5 → `X` = 0, one HOLD cycle (`irq` = 0), then IDLE.
3. Pulse `req[2]` and `req[6]` together → ASSERT with `X` = 8'h44. Ack id 6 → HOLD, then re-ASSERT with `X` = 8'h04 at ack+2. Ack id 2 → IDLE.
4. Hold `pend[3]` in ASSERT and drop `mask[3]` to 0 → IDLE next cycle and `pend[3]` stays 1. Restore `mask[3]` → ASSERT again.
5. In ASSERT with `pend[1]` = 1, issue `ack_id` = 1 in the same cycle as a new `req[1]` edge → `pend[1]` stays 1 and `overrun[1]` = 1. A second ack clears `pend[1]`; `overrun[1]` stays 1 until `rst`.
6. `IRQ_REQ_SYNC_EN` defined, pulse `req[0]` → `irq` rises 4 cycles after the edge. Assert `rst` while in ASSERT → outputs return to their reset values immediately, without waiting for a clock.
